dcache_axi_master: RTL and testbench

- Downstream neighbour of the L1 data cache. Consumes the cache's single-word memory-side request interface (D_req/D_addr/D_write/D_in/D_type) and returns D_out/D_wait.
- Converts each request into exactly one AXI4-Lite-style read or write transaction on the data-side bus towards the interconnect.
- Line refills arrive as four back-to-back word requests, and this block serialises them.

---
 rtl/dcache_axi_pkg.sv | 31 +++
 rtl/dcache_axi_master.sv | 137 +++++++++++++
 tb/tb_dcache_axi_master.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_axi_pkg.sv
// Shared types and helpers for the data-cache to AXI4-Lite bridge:
// FSM states, cache access-type codes, response codes and byte-strobe generation.
package dcache_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW_W,
    ST_B,
    ST_DONE
  } state_e;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Bit 2 of the type code only selects sign extension on loads, so it is
  // irrelevant for strobes; unknown codes fall back to a full-word write.
  function automatic logic [3:0] gen_wstrb(input logic [2:0] d_type,
                                           input logic [1:0] addr_lo);
    case (d_type)
      TYPE_BYTE, TYPE_BYTE | 3'b100: gen_wstrb = 4'b0001 << addr_lo;
      TYPE_HALF, TYPE_HALF | 3'b100: gen_wstrb = 4'b0011 << {addr_lo[1], 1'b0};
      default:                       gen_wstrb = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dcache_axi_master.sv
// Bridges the L1 data cache's single-word memory request port onto an
// AXI4-Lite master, one read or write transaction per request, never overlapped.
module dcache_axi_master
  import dcache_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                D_req,
  input  logic [ADDR_W-1:0]   D_addr,
  input  logic                D_write,
  input  logic [DATA_W-1:0]   D_in,
  input  logic [2:0]          D_type,
  output logic [DATA_W-1:0]   D_out,
  output logic                D_wait,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RVALID,
  output logic                RREADY,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic                resp_err
);

  localparam int STRB_W = DATA_W / 8;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   dout_q;
  logic [1:0]          resp_q;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  assign ARADDR = addr_q;
  assign AWADDR = addr_q;
  assign WDATA  = wdata_q;
  assign WSTRB  = wstrb_q;
  assign D_out  = dout_q;

  always_comb begin
    // NOTE: every output and next-state value gets a default before the case,
    // so no path through the block leaves a signal unassigned (no latches).
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    D_wait    = 1'b1;
    resp_err  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Combinational so the cache never sees a low D_wait before completion.
        D_wait = D_req;
        if (D_req) state_d = D_write ? ST_AW_W : ST_AR;
      end
      ST_AR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_d = ST_R;
      end
      ST_R: begin
        RREADY = 1'b1;
        if (RVALID) state_d = ST_DONE;
      end
      ST_AW_W: begin
        // Address and data channels handshake independently in any order.
        AWVALID   = !aw_done_q;
        WVALID    = !w_done_q;
        aw_done_d = aw_done_q || AWREADY;
        w_done_d  = w_done_q || WREADY;
        if (aw_done_d && w_done_d) begin
          state_d   = ST_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      ST_B: begin
        BREADY = 1'b1;
        if (BVALID) state_d = ST_DONE;
      end
      ST_DONE: begin
        D_wait   = 1'b0;
        resp_err = (resp_q != RESP_OKAY);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      dout_q    <= '0;
      resp_q    <= RESP_OKAY;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (state_q == ST_IDLE && D_req) begin
        addr_q  <= D_addr;
        wdata_q <= D_in;
        wstrb_q <= STRB_W'(gen_wstrb(D_type, D_addr[1:0]));
      end
      if (state_q == ST_R && RVALID) begin
        dout_q <= RDATA;
        resp_q <= RRESP;
      end
      if (state_q == ST_B && BVALID) resp_q <= BRESP;
    end
  end

endmodule

// File: tb/tb_dcache_axi_master.sv
// Randomised scoreboard bench for dcache_axi_master: a driver issues cache
// requests and queues expectations, reactive AXI slaves and a monitor compare.
module tb_dcache_axi_master;

  logic        clk, rst;
  logic        D_req, D_write;
  logic [31:0] D_addr, D_in, D_out;
  logic [2:0]  D_type;
  logic        D_wait;
  logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [1:0]  RRESP, BRESP;
  logic [3:0]  WSTRB;
  logic        resp_err;

  dcache_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .D_req(D_req), .D_addr(D_addr), .D_write(D_write), .D_in(D_in), .D_type(D_type),
    .D_out(D_out), .D_wait(D_wait),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] dout;
    bit          err;
  } exp_t;

  exp_t        exp_q[$];
  int          cfg_da, cfg_dw, cfg_dr;
  logic [31:0] cfg_rdata;
  logic [1:0]  cfg_resp;
  int          ar_cnt, aw_cnt, w_cnt, done_cnt;
  logic [31:0] last_dout;
  bit          in_done;
  int          nchecks, nerrors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference strobe: which byte lanes of the word a store of this size touches.
  function automatic logic [3:0] ref_strb(input logic [2:0] typ, input logic [31:0] addr);
    int lane;
    lane = int'(addr % 4);
    if (typ == 3'd0 || typ == 3'd4) return 4'(1 << lane);
    if (typ == 3'd1 || typ == 3'd5) return (lane >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // ---------------- reactive AXI slaves ----------------
  initial begin : ar_slave
    forever begin
      @(negedge clk);
      if (!rst && ARVALID) begin
        repeat (cfg_da) @(negedge clk);
        check("arvalid_stable", ARVALID, 1);
        if (exp_q.size() > 0) check("araddr", ARADDR, exp_q[0].addr);
        ARREADY = 1'b1;
        ar_cnt++;
        @(negedge clk);
        ARREADY = 1'b0;
      end
    end
  end

  initial begin : r_slave
    forever begin
      @(negedge clk);
      if (!rst && RREADY) begin
        repeat (cfg_dr) @(negedge clk);
        RDATA  = cfg_rdata;
        RRESP  = cfg_resp;
        RVALID = 1'b1;
        @(negedge clk);
        RVALID = 1'b0;
        RDATA  = $urandom;
        RRESP  = 2'($urandom);
      end
    end
  end

  initial begin : aw_slave
    forever begin
      @(negedge clk);
      if (!rst && AWVALID) begin
        repeat (cfg_da) @(negedge clk);
        check("awvalid_stable", AWVALID, 1);
        if (exp_q.size() > 0) check("awaddr", AWADDR, exp_q[0].addr);
        AWREADY = 1'b1;
        aw_cnt++;
        @(negedge clk);
        AWREADY = 1'b0;
      end
    end
  end

  initial begin : w_slave
    forever begin
      @(negedge clk);
      if (!rst && WVALID) begin
        repeat (cfg_dw) @(negedge clk);
        check("wvalid_stable", WVALID, 1);
        if (exp_q.size() > 0) begin
          check("wdata", WDATA, exp_q[0].data);
          check("wstrb", WSTRB, exp_q[0].strb);
        end
        WREADY = 1'b1;
        w_cnt++;
        @(negedge clk);
        WREADY = 1'b0;
      end
    end
  end

  initial begin : b_slave
    forever begin
      @(negedge clk);
      if (!rst && BREADY) begin
        repeat (cfg_dr) @(negedge clk);
        BRESP  = cfg_resp;
        BVALID = 1'b1;
        @(negedge clk);
        BVALID = 1'b0;
        BRESP  = 2'($urandom);
      end
    end
  end

  // ---------------- completion monitor ----------------
  // The cycle after an R or B handshake must be the single completion cycle.
  initial begin : done_monitor
    bit   hs_prev;
    exp_t e;
    hs_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        hs_prev = 1'b0;
      end else begin
        if (hs_prev) begin
          if (exp_q.size() == 0) begin
            check("done_without_request", D_wait, 1);
          end else begin
            e = exp_q.pop_front();
            check("done_d_wait", D_wait, 0);
            check("d_out", D_out, e.dout);
            check("resp_err_done", resp_err, e.err);
            check("ar_handshakes", ar_cnt, e.wr ? 0 : 1);
            check("aw_handshakes", aw_cnt, e.wr ? 1 : 0);
            check("w_handshakes", w_cnt, e.wr ? 1 : 0);
          end
          ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
          done_cnt++;
        end else begin
          check("resp_err_quiet", resp_err, 0);
          if (D_req) check("d_wait_busy", D_wait, 1);
        end
        hs_prev = (RVALID && RREADY) || (BVALID && BREADY);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic finish_reset(input int settle);
    exp_q.delete();
    last_dout = '0;
    D_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (settle) @(negedge clk);
    #2;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    in_done = 1'b0;
  endtask

  task automatic go_idle(input int n);
    D_req = 1'b0;
    in_done = 1'b0;
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [2:0] typ, input logic [31:0] rdata, input logic [1:0] resp,
                       input int da, input int dw, input int dr, input bit drop);
    exp_t e;
    int start, cycles, lat;
    e.wr   = wr;
    e.addr = addr;
    e.data = data;
    e.strb = ref_strb(typ, addr);
    e.dout = wr ? last_dout : rdata;
    e.err  = (resp != 2'b00);
    last_dout = e.dout;
    exp_q.push_back(e);
    cfg_da = da; cfg_dw = dw; cfg_dr = dr; cfg_rdata = rdata; cfg_resp = resp;
    // Cycles from request to completion: one idle cycle (two if still in the
    // previous completion), one per channel phase plus slave stalls, then done.
    lat = (in_done ? 4 : 3) + dr + (wr ? ((da > dw) ? da : dw) : da);
    D_req = 1'b1; D_write = wr; D_addr = addr; D_in = data; D_type = typ;
    start = done_cnt;
    cycles = 0;
    while (done_cnt == start && cycles < 200) begin
      @(negedge clk);
      #2;
      cycles++;
      if (drop && cycles == 1) D_req = 1'b0;
    end
    if (done_cnt == start) begin
      check("completion_timeout", 0, 1);
      rst = 1'b1;
      finish_reset(30);
    end else begin
      check("latency", cycles, lat);
      in_done = 1'b1;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    logic [31:0] a;
    nchecks = 0; nerrors = 0; done_cnt = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    last_dout = '0; in_done = 1'b0;
    cfg_da = 0; cfg_dw = 0; cfg_dr = 0; cfg_rdata = '0; cfg_resp = 2'b00;
    D_req = 0; D_write = 0; D_addr = '0; D_in = '0; D_type = 3'b010;
    ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = 2'b00;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 2'b00;
    rst = 1'b1;
    #1;
    check("rst_arvalid", ARVALID, 0);
    check("rst_rready", RREADY, 0);
    check("rst_awvalid", AWVALID, 0);
    check("rst_wvalid", WVALID, 0);
    check("rst_bready", BREADY, 0);
    check("rst_d_wait", D_wait, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_d_out", D_out, last_dout);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    go_idle(1);

    // Basic zero-wait read.
    issue(0, 32'h0000_1230, 32'h0, 3'b010, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0);
    go_idle(2);

    // Line refill: request held high while the word index advances.
    for (int i = 0; i < 4; i++)
      issue(0, 32'h100 + 32'(4 * i), 32'h0, 3'b010, $urandom, 2'b00, 0, 0, 0, 0);
    go_idle(2);

    // Byte and half stores in the upper lanes.
    issue(1, 32'h203, 32'hAB00_0000, 3'b000, 32'h0, 2'b00, 0, 0, 0, 0);
    go_idle(1);
    issue(1, 32'h202, 32'hCDEF_0000, 3'b001, 32'h0, 2'b00, 0, 0, 0, 0);
    go_idle(1);

    // Address accepted at once, data three cycles later.
    issue(1, 32'h400, 32'h1234_5678, 3'b010, 32'h0, 2'b00, 0, 3, 1, 0);
    go_idle(1);
    // Data first, address later.
    issue(1, 32'h404, 32'h8765_4321, 3'b010, 32'h0, 2'b00, 2, 0, 0, 0);
    go_idle(1);

    // Error responses on both paths.
    issue(1, 32'h500, 32'h5555_AAAA, 3'b010, 32'h0, 2'b10, 0, 0, 0, 0);
    go_idle(1);
    issue(0, 32'h504, 32'h0, 3'b010, 32'h0BAD_F00D, 2'b11, 1, 0, 2, 0);
    go_idle(1);

    // Request withdrawn while the transaction is in flight.
    issue(0, 32'h600, 32'h0, 3'b010, 32'hC0FF_EE00, 2'b00, 1, 0, 1, 1);
    go_idle(2);

    // Reset while waiting for read data.
    a = 32'h0000_0700;
    exp_q.push_back('{wr: 1'b0, addr: a, data: 32'h0, strb: 4'hF, dout: 32'h0, err: 1'b0});
    cfg_da = 0; cfg_dr = 20; cfg_rdata = 32'h1111_2222; cfg_resp = 2'b00;
    D_req = 1'b1; D_write = 1'b0; D_addr = a; D_type = 3'b010;
    for (int i = 0; i < 20 && !RREADY; i++) begin
      @(negedge clk);
      #2;
    end
    check("reached_read_data_phase", RREADY, 1);
    D_req = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_rready", RREADY, 0);
    check("mid_rst_arvalid", ARVALID, 0);
    check("mid_rst_awvalid", AWVALID, 0);
    check("mid_rst_wvalid", WVALID, 0);
    check("mid_rst_bready", BREADY, 0);
    check("mid_rst_d_wait", D_wait, 0);
    check("mid_rst_d_out", D_out, 0);
    finish_reset(25);
    issue(0, 32'h0000_0800, 32'h0, 3'b010, 32'h3333_4444, 2'b00, 0, 0, 0, 0);

    // Randomised mix of reads and writes, stalls, gaps and withdrawn requests.
    for (int i = 0; i < 80; i++) begin
      bit          b2b, wr, drop;
      logic [1:0]  resp;
      b2b  = bit'($urandom_range(0, 1));
      wr   = bit'($urandom_range(0, 1));
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      drop = !b2b && ($urandom_range(0, 3) == 0);
      if (!b2b) go_idle($urandom_range(1, 3));
      issue(wr, $urandom, $urandom, 3'($urandom_range(0, 7)), $urandom, resp,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), drop);
    end
    go_idle(3);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
